multiword_add_sequencer: RTL and testbench

Multi-cycle wide adder controller that sits directly upstream of the 4-bit ripple_carry_adder and drives it. It accepts two WIDTH-bit operands over a valid/ready handshake and presents one 4-bit slice per clock to the adder. The adder's carry-out is registered and fed back as the next slice's carry-in. The assembled sum and final carry are returned over a valid/ready handshake, giving WIDTH-bit addition with a single 4-bit adder.

---
 rtl/add_pkg.sv | 23 ++
 rtl/ripple_carry_adder.sv | 24 ++
 rtl/multiword_add_sequencer.sv | 96 +++++++++
 tb/tb_multiword_add_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the multi-word adder sequencer: slice width,
// controller states and an index-width helper.
package add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder shared by every slice of the wide addition.
module ripple_carry_adder
    import add_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               C,
    output logic [SLICE_W-1:0] S,
    output logic               Cout
);

    logic carry;

    always_comb begin
        S     = '0;
        carry = C;
        for (int i = 0; i < SLICE_W; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two WIDTH-bit operands one 4-bit slice per clock through a single
// ripple_carry_adder, carrying between slices only through carry_reg.
module multiword_add_sequencer
    import add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

    state_t state, next_state;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_cout;

    assign slice_a = a_reg[SLICE_W*int'(idx) +: SLICE_W];
    assign slice_b = b_reg[SLICE_W*int'(idx) +: SLICE_W];

    ripple_carry_adder u_adder (
        .A    (slice_a),
        .B    (slice_b),
        .C    (carry_reg),
        .S    (slice_s),
        .Cout (slice_cout)
    );

    // Handshake outputs decode straight from state so reset drops them at once
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (idx == LAST) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        sum       <= '0;
                    end
                end
                RUN: begin
                    sum[SLICE_W*int'(idx) +: SLICE_W] <= slice_s;
                    carry_reg <= slice_cout;
                    // Index parks on the top slice rather than wrapping
                    if (idx == LAST) cout <= slice_cout;
                    else             idx  <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed-vector bench for multiword_add_sequencer at WIDTH=16.
module tb_multiword_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multiword_add_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present operands for one cycle; returns just after the accepting edge
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        @(negedge clk);
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output logic ready_seen);
        cycles = 0;
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) ready_seen = 1'b1;
            cycles++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        logic rs;
        start_op(16'h0009, 16'h0007, 1'b0);
        wait_done(cyc, rs);
        checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 4", cyc); end
        checks++; if (sum !== 16'h0010) begin errors++; $display("[TB] FAIL basic_sum: got %h expected 0010", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL basic_cout: got %b expected 0", cout); end
        checks++; if (rs !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_in_run: got %b expected 0", rs); end
        finish_op();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_after: got ready=%b busy=%b expected ready=1 busy=0", in_ready, busy); end
    endtask

    task automatic test_full_ripple();
        start_op(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (dut.carry_reg !== 1'b1) begin errors++; $display("[TB] FAIL ripple_carry_slice%0d: got %b expected 1", i - 1, dut.carry_reg); end
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ripple_out_valid: got %b expected 1", out_valid); end
        checks++; if (dut.carry_reg !== 1'b1) begin errors++; $display("[TB] FAIL ripple_carry_slice3: got %b expected 1", dut.carry_reg); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL ripple_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL ripple_cout: got %b expected 1", cout); end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic rs;
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(cyc, rs);
        checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL b2b1_latency: got %0d expected 4", cyc); end
        checks++; if (sum !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b1_sum: got %h expected FFFF", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL b2b1_cout: got %b expected 1", cout); end
        checks++; if (rs !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b1_ready_busy: got run=%b done=%b expected 0 0", rs, in_ready); end
        finish_op();
        start_op(16'h0000, 16'h0000, 1'b0);
        wait_done(cyc, rs);
        checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL b2b2_latency: got %0d expected 4", cyc); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL b2b2_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL b2b2_cout: got %b expected 0", cout); end
        checks++; if (rs !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b2_ready_busy: got run=%b done=%b expected 0 0", rs, in_ready); end
        finish_op();
    endtask

    task automatic test_stall();
        int cyc;
        logic rs;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(cyc, rs);
        checks++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL stall_sum: got %h expected 5555", sum); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || sum !== 16'h5555 || cout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b sum=%h cout=%b expected 1 5555 0", i, out_valid, sum, cout);
            end
        end
        finish_op();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got busy=%b ready=%b valid=%b expected 0 1 0", busy, in_ready, out_valid); end
    endtask

    task automatic test_operand_change();
        int cyc;
        logic rs;
        start_op(16'h8000, 16'h8000, 1'b0);
        a = 16'h0001;
        b = 16'h1111;
        cin = 1'b1;
        in_valid = 1'b1;
        wait_done(cyc, rs);
        in_valid = 1'b0;
        checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL latch_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL latch_cout: got %b expected 1", cout); end
        finish_op();
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        logic rs;
        start_op(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready_busy: got ready=%b busy=%b expected 1 0", in_ready, busy); end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin errors++; $display("[TB] FAIL midrst_result: got sum=%h cout=%b expected 0000 0", sum, cout); end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'h0003, 16'h0004, 1'b0);
        wait_done(cyc, rs);
        checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected 4", cyc); end
        checks++; if (sum !== 16'h0007) begin errors++; $display("[TB] FAIL midrst_sum: got %h expected 0007", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cout: got %b expected 0", cout); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_ripple();
        test_back_to_back();
        test_stall();
        test_operand_change();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
